// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract that ripples CHUNK bits per clock behind
// valid/ready handshakes; reports carry-out (no-borrow in sub) and signed overflow.
//   state | meaning
//   IDLE  | waiting for operands (in_ready high once out of reset)
//   RUN   | one CHUNK slice of the sum per cycle, N cycles
//   DONE  | result held until the consumer takes it
module chunked_serial_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o,
  output logic             ovf_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
    $error("chunked_serial_adder: CHUNK must be in 1..WIDTH");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_multiple
    $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] beff_q, beff_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  int               idx;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;

  always_comb begin
    idx       = int'(k_q) * CHUNK;
    a_chunk   = a_q[idx +: CHUNK];
    b_chunk   = beff_q[idx +: CHUNK];
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    beff_d  = beff_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    k_d     = k_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_ready_q && in_valid_i) begin
          a_d     = a_i;
          beff_d  = sub_i ? ~b_i : b_i;
          carry_d = c_in_i ^ sub_i;
          sum_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx +: CHUNK] = chunk_res[CHUNK-1:0];
        carry_d             = chunk_res[CHUNK];
        if (k_q == KW'(N - 1)) begin
          // MSB of the final slice is the sign bit of the finished sum.
          c_out_d = chunk_res[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == beff_q[WIDTH-1]) &&
                    (chunk_res[CHUNK-1] != a_q[WIDTH-1]);
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      a_q        <= '0;
      beff_q     <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      k_q        <= '0;
      c_out_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      a_q        <= a_d;
      beff_q     <= beff_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
      k_q        <= k_d;
      c_out_q    <= c_out_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign c_out_o     = c_out_q;
  assign ovf_o       = ovf_q;

endmodule
